// File: rtl/regfile_pkg.sv
// Shared types and sizes for the register-file writeback scheduler.
// Latency: n/a (declarations only).
// Backpressure: n/a.
package regfile_pkg;

    localparam int NREG = 16;
    localparam int AW   = 4;
    localparam int DW   = 32;

    typedef enum logic {
        NORMAL = 1'b0,
        FORCE  = 1'b1
    } wb_state_t;

    typedef struct packed {
        logic          valid;
        logic [AW-1:0] rd;
        logic [DW-1:0] data;
    } wb_req_t;

    // One-hot register mask, all zero when en is low.
    function automatic logic [NREG-1:0] reg_onehot(input logic [AW-1:0] r, input logic en);
        reg_onehot = en ? (NREG'(1) << r) : '0;
    endfunction

endpackage

// File: rtl/regfile_scoreboard.sv
// Per-register pending-write scoreboard: RAW/WAW issue stall and writeback sanity flag.
// Latency: issue_ready combinational; pend set/cleared at the next edge; wb_err visible in the write cycle, sticky after.
// Backpressure: holds decode (issue_ready=0) while any used source or the destination is pending.
// Ports: i_clk/i_reset; i_issue_* decode request in, o_issue_ready out;
//        i_wb_vld/i_wb_rd the register-file write currently presented; o_pend vector, o_wb_err sticky flag.
module regfile_scoreboard
    import regfile_pkg::*;
(
    input  logic            i_clk,
    input  logic            i_reset,
    input  logic            i_issue_valid,
    input  logic [AW-1:0]   i_issue_rs1,
    input  logic            i_issue_use1,
    input  logic [AW-1:0]   i_issue_rs2,
    input  logic            i_issue_use2,
    input  logic [AW-1:0]   i_issue_rd,
    input  logic            i_issue_we,
    input  logic            i_wb_vld,
    input  logic [AW-1:0]   i_wb_rd,
    output logic            o_issue_ready,
    output logic [NREG-1:0] o_pend,
    output logic            o_wb_err
);

    logic [NREG-1:0] r_pend;
    logic            r_wb_err;
    logic            w_hz;
    logic            w_issue_acc;
    logic            w_err_now;
    logic [NREG-1:0] w_set;
    logic [NREG-1:0] w_clr;

    always_comb begin
        // Hazard uses the pend vector as it stands this cycle; a write in flight
        // releases its dependants only from the cycle after the register-file write.
        w_hz        = (i_issue_use1 & r_pend[i_issue_rs1])
                    | (i_issue_use2 & r_pend[i_issue_rs2])
                    | (i_issue_we   & r_pend[i_issue_rd]);
        w_issue_acc = i_issue_valid & ~w_hz & ~i_reset;
        w_set       = reg_onehot(i_issue_rd, w_issue_acc & i_issue_we);
        w_clr       = reg_onehot(i_wb_rd, i_wb_vld);
        w_err_now   = i_wb_vld & ~r_pend[i_wb_rd];
    end

    always_ff @(posedge i_clk) begin
        if (i_reset) begin
            r_pend   <= '0;
            r_wb_err <= 1'b0;
        end else begin
            // Set is applied after clear so a same-edge set of the written register wins.
            r_pend <= (r_pend & ~w_clr) | w_set;
            if (w_err_now) begin
                r_wb_err <= 1'b1;
            end
        end
    end

    assign o_issue_ready = w_issue_acc;
    assign o_pend        = r_pend;
    assign o_wb_err      = r_wb_err | w_err_now;

endmodule

// File: rtl/regfile_wb_scheduler.sv
// Owns the register-file write port: arbitrates ALU vs mem writeback with bounded mem starvation, plus issue scoreboard.
// Latency: grant combinational with request; rf_iswb/rf_a3/rf_d3 one cycle after grant.
// Backpressure: ALU wins by default; mem forced after STARVE_LIMIT consecutive losses; decode stalled on hazards.
// Ports: i_clk/i_reset; i_issue_* / o_issue_ready decode side; i_alu_* / o_alu_ready and i_mem_* / o_mem_ready
//        writeback requesters; o_rf_iswb/o_rf_a3/o_rf_d3 register-file write port; o_pend, o_wb_err debug.
module regfile_wb_scheduler
    import regfile_pkg::*;
#(
    parameter int STARVE_LIMIT = 4
) (
    input  logic            i_clk,
    input  logic            i_reset,
    input  logic            i_issue_valid,
    input  logic [AW-1:0]   i_issue_rs1,
    input  logic            i_issue_use1,
    input  logic [AW-1:0]   i_issue_rs2,
    input  logic            i_issue_use2,
    input  logic [AW-1:0]   i_issue_rd,
    input  logic            i_issue_we,
    output logic            o_issue_ready,
    input  logic            i_alu_valid,
    input  logic [AW-1:0]   i_alu_rd,
    input  logic [DW-1:0]   i_alu_data,
    output logic            o_alu_ready,
    input  logic            i_mem_valid,
    input  logic [AW-1:0]   i_mem_rd,
    input  logic [DW-1:0]   i_mem_data,
    output logic            o_mem_ready,
    output logic            o_rf_iswb,
    output logic [AW-1:0]   o_rf_a3,
    output logic [DW-1:0]   o_rf_d3,
    output logic [NREG-1:0] o_pend,
    output logic            o_wb_err
);

    localparam int CW = $clog2(STARVE_LIMIT + 1);

    wb_state_t     r_state;
    logic [CW-1:0] r_cnt;
    logic          r_iswb;
    logic [AW-1:0] r_a3;
    logic [DW-1:0] r_d3;

    wb_req_t w_alu;
    wb_req_t w_mem;
    wb_req_t w_gnt;
    logic    w_alu_rdy;
    logic    w_mem_rdy;
    logic    w_alu_gnt;
    logic    w_mem_gnt;

    always_comb begin
        w_alu     = '{valid: i_alu_valid, rd: i_alu_rd, data: i_alu_data};
        w_mem     = '{valid: i_mem_valid, rd: i_mem_rd, data: i_mem_data};
        w_alu_rdy = 1'b0;
        w_mem_rdy = 1'b0;
        // Nothing is granted in a reset cycle, so no write lands after reset.
        if (!i_reset) begin
            case (r_state)
                NORMAL: begin
                    w_alu_rdy = 1'b1;
                    w_mem_rdy = ~w_alu.valid;
                end
                FORCE: begin
                    w_mem_rdy = w_mem.valid;
                    w_alu_rdy = ~w_mem.valid;
                end
                default: begin
                    w_alu_rdy = 1'b0;
                    w_mem_rdy = 1'b0;
                end
            endcase
        end
        // Ready terms are mutually exclusive whenever both requesters are valid.
        w_alu_gnt   = w_alu.valid & w_alu_rdy;
        w_mem_gnt   = w_mem.valid & w_mem_rdy;
        w_gnt       = w_alu_gnt ? w_alu : w_mem;
        w_gnt.valid = w_alu_gnt | w_mem_gnt;
    end

    always_ff @(posedge i_clk) begin
        if (i_reset) begin
            r_state <= NORMAL;
            r_cnt   <= '0;
            r_iswb  <= 1'b0;
            r_a3    <= '0;
            r_d3    <= '0;
        end else begin
            r_iswb <= w_gnt.valid;
            if (w_gnt.valid) begin
                r_a3 <= w_gnt.rd;
                r_d3 <= w_gnt.data;
            end
            case (r_state)
                NORMAL: begin
                    if (w_mem.valid && !w_mem_gnt) begin
                        // Count consecutive mem losses; the last permitted loss arms FORCE.
                        if (r_cnt == CW'(STARVE_LIMIT - 1)) begin
                            r_state <= FORCE;
                            r_cnt   <= '0;
                        end else begin
                            r_cnt <= r_cnt + 1'b1;
                        end
                    end else begin
                        r_cnt <= '0;
                    end
                end
                FORCE: begin
                    r_state <= NORMAL;
                    r_cnt   <= '0;
                end
                default: begin
                    r_state <= NORMAL;
                    r_cnt   <= '0;
                end
            endcase
        end
    end

    regfile_scoreboard u_sb (
        .i_clk         (i_clk),
        .i_reset       (i_reset),
        .i_issue_valid (i_issue_valid),
        .i_issue_rs1   (i_issue_rs1),
        .i_issue_use1  (i_issue_use1),
        .i_issue_rs2   (i_issue_rs2),
        .i_issue_use2  (i_issue_use2),
        .i_issue_rd    (i_issue_rd),
        .i_issue_we    (i_issue_we),
        .i_wb_vld      (r_iswb),
        .i_wb_rd       (r_a3),
        .o_issue_ready (o_issue_ready),
        .o_pend        (o_pend),
        .o_wb_err      (o_wb_err)
    );

    assign o_alu_ready = w_alu_rdy;
    assign o_mem_ready = w_mem_rdy;
    assign o_rf_iswb   = r_iswb;
    assign o_rf_a3     = r_a3;
    assign o_rf_d3     = r_d3;

endmodule
